// File: rtl/md5_load_responder.sv
// Load-side responder for the MD5 word-load protocol: assembles load beats
// into one message block, hands it to the round engine and returns the digest.
module md5_load_responder #(
  parameter int unsigned WORD_W = 128,
  parameter int unsigned BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      newtext_i,
  input  logic                      load_i,
  input  logic [WORD_W-1:0]         data_i,
  output logic [WORD_W-1:0]         data_o,
  output logic                      ready_o,
  output logic                      busy_o,
  output logic                      err_o,
  output logic [WORD_W*BEATS-1:0]   blk_o,
  output logic                      first_o,
  output logic                      blk_valid_o,
  input  logic                      blk_ready_i,
  input  logic [WORD_W-1:0]         dig_i,
  input  logic                      dig_valid_i
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT_DIG} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               msg_open;
  logic               first_blk;
  logic [WORD_W-1:0]  slot [BEATS];

  // Protocol FSM; newtext_i overrides every state and restarts the message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      msg_open    <= 1'b0;
      first_blk   <= 1'b0;
      data_o      <= '0;
      ready_o     <= 1'b0;
      err_o       <= 1'b0;
      blk_valid_o <= 1'b0;
      for (int i = 0; i < int'(BEATS); i++) slot[i] <= '0;
    end else if (newtext_i) begin
      first_blk   <= 1'b1;
      msg_open    <= 1'b1;
      ready_o     <= 1'b0;
      data_o      <= '0;
      err_o       <= 1'b0;
      blk_valid_o <= 1'b0;
      state       <= FILL;
      if (load_i) begin
        slot[0] <= data_i;
        cnt     <= CNT_W'(1);
      end else begin
        cnt     <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (load_i) begin
            if (msg_open) begin
              slot[0] <= data_i;
              cnt     <= CNT_W'(1);
              ready_o <= 1'b0;
              state   <= FILL;
            end else begin
              err_o   <= 1'b1;
            end
          end
        end
        FILL: begin
          if (load_i) begin
            slot[cnt] <= data_i;
            if (cnt == LAST) begin
              cnt         <= '0;
              blk_valid_o <= 1'b1;
              state       <= ISSUE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ISSUE: begin
          if (load_i) err_o <= 1'b1;
          if (blk_ready_i) begin
            blk_valid_o <= 1'b0;
            first_blk   <= 1'b0;
            state       <= WAIT_DIG;
          end
        end
        WAIT_DIG: begin
          if (load_i) err_o <= 1'b1;
          if (dig_valid_i) begin
            data_o  <= dig_i;
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slot 0 is the most significant word of the block.
  for (genvar i = 0; i < int'(BEATS); i++) begin : g_blk
    assign blk_o[(int'(BEATS) - 1 - i)*int'(WORD_W) +: int'(WORD_W)] = slot[i];
  end

  assign busy_o  = (state == ISSUE) || (state == WAIT_DIG);
  assign first_o = first_blk & blk_valid_o;

endmodule
